// File: rtl/cmsdk_debug_cmd_sequencer_if.sv
// Bus bundle between the StdOut UART receiver, the debug tester and the command sequencer.
// The sequencer takes the slave modport; whoever drives the stream and tester flags takes master.
interface cmsdk_debug_cmd_sequencer_if;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       DEBUG_RUNNING;
  logic       DEBUG_ERR;
  logic       STATUS_CLR;
  logic       DEBUG_TEST_EN;
  logic [5:0] DEBUG_COMMAND;
  logic       DEBUG_START;
  logic       BUSY;
  logic       CMD_DONE;
  logic       CMD_PASS;
  logic       ERR_STICKY;
  logic       TIMEOUT_STICKY;
  logic       OVERFLOW_STICKY;

  modport slave (
    input  RX_DATA, RX_VALID, DEBUG_RUNNING, DEBUG_ERR, STATUS_CLR,
    output DEBUG_TEST_EN, DEBUG_COMMAND, DEBUG_START, BUSY, CMD_DONE, CMD_PASS,
           ERR_STICKY, TIMEOUT_STICKY, OVERFLOW_STICKY
  );

  modport master (
    output RX_DATA, RX_VALID, DEBUG_RUNNING, DEBUG_ERR, STATUS_CLR,
    input  DEBUG_TEST_EN, DEBUG_COMMAND, DEBUG_START, BUSY, CMD_DONE, CMD_PASS,
           ERR_STICKY, TIMEOUT_STICKY, OVERFLOW_STICKY
  );
endinterface

// File: rtl/cmsdk_debug_cmd_sequencer.sv
// Debug-tester command sequencer: decodes ESC-prefixed UART bytes, owns the tester enable,
// issues one 6-bit command at a time and tracks the tester running/error handshake with a timeout.
module cmsdk_debug_cmd_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter logic [7:0]  ESC_CODE       = 8'h1B
) (
  input  logic                        CLK,
  input  logic                        RESET,
  cmsdk_debug_cmd_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_RUN = 2'd1, WAIT_DONE = 2'd2} state_t;

  localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES - 1);

  function automatic logic [19:0] sat_inc(input logic [19:0] v);
    return (v == 20'hFFFFF) ? v : v + 20'd1;
  endfunction

  state_t      state_q, state_d;
  logic [19:0] timer_q, timer_d;
  logic [5:0]  pend_cmd_q, pend_cmd_d;
  logic [5:0]  cmd_q, cmd_d;
  logic        esc_seen_q, esc_seen_d;
  logic        en_q, en_d;
  logic        dis_pend_q, dis_pend_d;
  logic        pend_valid_q, pend_valid_d;
  logic        start_q, start_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        err_st_q, err_st_d;
  logic        to_st_q, to_st_d;
  logic        ovf_st_q, ovf_st_d;
  logic        run_s1_q, run_s1_d, run_s2_q, run_s2_d;
  logic        err_s1_q, err_s1_d, err_s2_q, err_s2_d;

  logic rx_esc, rx_dec, req_en, req_dis, req_cmd, issue;
  logic to_idle, err_set, to_set, ovf_set;

  always_comb begin
    rx_esc  = bus.RX_VALID && (bus.RX_DATA == ESC_CODE);
    rx_dec  = bus.RX_VALID && esc_seen_q && (bus.RX_DATA != ESC_CODE);
    req_en  = rx_dec && (bus.RX_DATA == 8'h11);
    req_dis = rx_dec && (bus.RX_DATA == 8'h12);
    req_cmd = rx_dec && (bus.RX_DATA[7:5] == 3'b001);
    issue   = (state_q == IDLE) && pend_valid_q && en_q;

    esc_seen_d = bus.RX_VALID ? rx_esc : esc_seen_q;
    state_d    = state_q;
    timer_d    = timer_q;
    cmd_d      = cmd_q;
    pass_d     = pass_q;
    start_d    = 1'b0;
    done_d     = 1'b0;
    to_idle    = 1'b0;
    err_set    = 1'b0;
    to_set     = 1'b0;
    ovf_set    = 1'b0;

    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d = WAIT_RUN;
          cmd_d   = pend_cmd_q;
          start_d = 1'b1;
          timer_d = '0;
        end
      end
      WAIT_RUN: begin
        if (run_s2_q) begin
          state_d = WAIT_DONE;
          timer_d = '0;
        end else if (timer_q == TMO_LAST) begin
          to_set = 1'b1;
        end else begin
          timer_d = sat_inc(timer_q);
        end
      end
      WAIT_DONE: begin
        if (!run_s2_q) begin
          state_d = IDLE;
          to_idle = 1'b1;
          done_d  = 1'b1;
          pass_d  = ~err_s2_q;
          err_set = err_s2_q;
        end else if (timer_q == TMO_LAST) begin
          to_set = 1'b1;
        end else begin
          timer_d = sat_inc(timer_q);
        end
      end
      default: state_d = IDLE;
    endcase

    if (to_set) begin
      state_d = IDLE;
      to_idle = 1'b1;
      done_d  = 1'b1;
      pass_d  = 1'b0;
    end

    // Single-entry slot: refill is allowed on the edge its current occupant issues.
    pend_valid_d = pend_valid_q && !issue;
    pend_cmd_d   = pend_cmd_q;
    if (req_cmd) begin
      if (!pend_valid_q || issue) begin
        pend_valid_d = 1'b1;
        pend_cmd_d   = bus.RX_DATA[5:0];
      end else begin
        ovf_set = 1'b1;
      end
    end

    // A disable outside IDLE is held back until the running command completes.
    en_d       = en_q;
    dis_pend_d = dis_pend_q;
    if (req_en) begin
      en_d       = 1'b1;
      dis_pend_d = 1'b0;
    end else if (req_dis && (state_q == IDLE)) begin
      en_d       = 1'b0;
      dis_pend_d = 1'b0;
    end else if ((req_dis || dis_pend_q) && to_idle) begin
      en_d       = 1'b0;
      dis_pend_d = 1'b0;
    end else if (req_dis) begin
      dis_pend_d = 1'b1;
    end

    err_st_d = err_set | (err_st_q & ~bus.STATUS_CLR);
    to_st_d  = to_set  | (to_st_q  & ~bus.STATUS_CLR);
    ovf_st_d = ovf_set | (ovf_st_q & ~bus.STATUS_CLR);

    run_s1_d = bus.DEBUG_RUNNING;
    run_s2_d = run_s1_q;
    err_s1_d = bus.DEBUG_ERR;
    err_s2_d = err_s1_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      pend_cmd_q   <= '0;
      cmd_q        <= '0;
      esc_seen_q   <= 1'b0;
      en_q         <= 1'b0;
      dis_pend_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      start_q      <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_st_q     <= 1'b0;
      to_st_q      <= 1'b0;
      ovf_st_q     <= 1'b0;
      run_s1_q     <= 1'b0;
      run_s2_q     <= 1'b0;
      err_s1_q     <= 1'b0;
      err_s2_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      pend_cmd_q   <= pend_cmd_d;
      cmd_q        <= cmd_d;
      esc_seen_q   <= esc_seen_d;
      en_q         <= en_d;
      dis_pend_q   <= dis_pend_d;
      pend_valid_q <= pend_valid_d;
      start_q      <= start_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_st_q     <= err_st_d;
      to_st_q      <= to_st_d;
      ovf_st_q     <= ovf_st_d;
      run_s1_q     <= run_s1_d;
      run_s2_q     <= run_s2_d;
      err_s1_q     <= err_s1_d;
      err_s2_q     <= err_s2_d;
    end
  end

  assign bus.DEBUG_TEST_EN   = en_q;
  assign bus.DEBUG_COMMAND   = cmd_q;
  assign bus.DEBUG_START     = start_q;
  assign bus.BUSY            = pend_valid_q | (state_q != IDLE);
  assign bus.CMD_DONE        = done_q;
  assign bus.CMD_PASS        = pass_q;
  assign bus.ERR_STICKY      = err_st_q;
  assign bus.TIMEOUT_STICKY  = to_st_q;
  assign bus.OVERFLOW_STICKY = ovf_st_q;
endmodule

// File: tb/tb_cmsdk_debug_cmd_sequencer.sv
// Scenario bench for cmsdk_debug_cmd_sequencer with a 16-cycle timeout; expected values come
// from the command protocol rules (ESC decoding, one-slot queue, handshake latencies).
module tb_cmsdk_debug_cmd_sequencer;
  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  cmsdk_debug_cmd_sequencer_if bus();

  cmsdk_debug_cmd_sequencer #(
    .TIMEOUT_CYCLES(16),
    .ESC_CODE      (8'h1B)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.RX_DATA  = b;
    bus.RX_VALID = 1'b1;
    step();
    bus.RX_VALID = 1'b0;
    bus.RX_DATA  = 8'h00;
  endtask

  task automatic pulse_clr();
    bus.STATUS_CLR = 1'b1;
    step();
    bus.STATUS_CLR = 1'b0;
  endtask

  task automatic wait_start(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (bus.DEBUG_START === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Tester side: run for len cycles, then drop RUNNING with the given error flag.
  task automatic finish_cmd(input int len, input logic err, output int n);
    bus.DEBUG_RUNNING = 1'b1;
    repeat (len) step();
    bus.DEBUG_ERR     = err;
    bus.DEBUG_RUNNING = 1'b0;
    n = -1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (bus.CMD_DONE === 1'b1) begin
        n = i;
        break;
      end
    end
    bus.DEBUG_ERR = 1'b0;
  endtask

  function automatic logic [7:0] rand_cmd_byte();
    return 8'h20 + 8'($urandom_range(0, 31));
  endfunction

  task automatic test_reset();
    logic [15:0] outs;
    RESET = 1'b1;
    bus.RX_DATA = 8'h00; bus.RX_VALID = 1'b0;
    bus.DEBUG_RUNNING = 1'b0; bus.DEBUG_ERR = 1'b0; bus.STATUS_CLR = 1'b0;
    repeat (3) step();
    RESET = 1'b0;
    outs = {bus.DEBUG_TEST_EN, bus.DEBUG_COMMAND, bus.DEBUG_START, bus.BUSY, bus.CMD_DONE,
            bus.CMD_PASS, bus.ERR_STICKY, bus.TIMEOUT_STICKY, bus.OVERFLOW_STICKY};
    nvec++; if (outs !== 16'h0) begin nerr++; $display("FAIL reset_outputs: got %h want 0000", outs); end
    step();
    nvec++; if (bus.BUSY !== 1'b0) begin nerr++; $display("FAIL reset_idle_busy: got %b want 0", bus.BUSY); end
  endtask

  task automatic test_enable_cmd();
    logic [7:0] b;
    int n, len;
    send(8'h1B); send(8'h11);
    nvec++; if (bus.DEBUG_TEST_EN !== 1'b1) begin nerr++; $display("FAIL enable: got %b want 1", bus.DEBUG_TEST_EN); end
    for (int it = 0; it < 3; it++) begin
      b = (it == 0) ? 8'h25 : rand_cmd_byte();
      len = (it == 0) ? 10 : $urandom_range(3, 10);
      send(8'h1B); send(b);
      nvec++; if (bus.BUSY !== 1'b1 || bus.DEBUG_START !== 1'b0) begin nerr++; $display("FAIL enq_busy: busy %b start %b want 1 0", bus.BUSY, bus.DEBUG_START); end
      wait_start(4, n);
      nvec++; if (n !== 1) begin nerr++; $display("FAIL start_latency: got %0d want 1", n); end
      nvec++; if (bus.DEBUG_COMMAND !== b[5:0]) begin nerr++; $display("FAIL command: got %h want %h", bus.DEBUG_COMMAND, b[5:0]); end
      step();
      nvec++; if (bus.DEBUG_START !== 1'b0 || bus.BUSY !== 1'b1) begin nerr++; $display("FAIL start_pulse: start %b busy %b want 0 1", bus.DEBUG_START, bus.BUSY); end
      finish_cmd(len, 1'b0, n);
      nvec++; if (n !== 3) begin nerr++; $display("FAIL done_latency: got %0d want 3", n); end
      nvec++; if (bus.CMD_PASS !== 1'b1 || bus.ERR_STICKY !== 1'b0) begin nerr++; $display("FAIL pass: pass %b err %b want 1 0", bus.CMD_PASS, bus.ERR_STICKY); end
      step();
      nvec++; if (bus.CMD_DONE !== 1'b0 || bus.BUSY !== 1'b0 || bus.DEBUG_COMMAND !== b[5:0]) begin
        nerr++; $display("FAIL after_done: done %b busy %b cmd %h want 0 0 %h", bus.CMD_DONE, bus.BUSY, bus.DEBUG_COMMAND, b[5:0]);
      end
    end
  endtask

  task automatic test_error();
    logic [7:0] b;
    int n;
    b = rand_cmd_byte();
    send(8'h1B); send(b);
    wait_start(4, n);
    nvec++; if (n !== 1) begin nerr++; $display("FAIL err_start: got %0d want 1", n); end
    finish_cmd($urandom_range(3, 10), 1'b1, n);
    nvec++; if (n !== 3) begin nerr++; $display("FAIL err_done_latency: got %0d want 3", n); end
    nvec++; if (bus.CMD_PASS !== 1'b0 || bus.ERR_STICKY !== 1'b1) begin nerr++; $display("FAIL err_result: pass %b err %b want 0 1", bus.CMD_PASS, bus.ERR_STICKY); end
    step(); step();
    nvec++; if (bus.ERR_STICKY !== 1'b1 || bus.CMD_PASS !== 1'b0) begin nerr++; $display("FAIL err_hold: err %b pass %b want 1 0", bus.ERR_STICKY, bus.CMD_PASS); end
    pulse_clr();
    nvec++; if (bus.ERR_STICKY !== 1'b0) begin nerr++; $display("FAIL err_clear: got %b want 0", bus.ERR_STICKY); end
  endtask

  task automatic test_timeout();
    int n, m;
    send(8'h1B); send(rand_cmd_byte());
    wait_start(4, n);
    m = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (bus.CMD_DONE === 1'b1) begin m = i; break; end
    end
    nvec++; if (m !== 16) begin nerr++; $display("FAIL timeout_cycles: got %0d want 16", m); end
    nvec++; if (bus.TIMEOUT_STICKY !== 1'b1 || bus.CMD_PASS !== 1'b0 || bus.ERR_STICKY !== 1'b0) begin
      nerr++; $display("FAIL timeout_flags: to %b pass %b err %b want 1 0 0", bus.TIMEOUT_STICKY, bus.CMD_PASS, bus.ERR_STICKY);
    end
    step();
    nvec++; if (bus.CMD_DONE !== 1'b0 || bus.BUSY !== 1'b0) begin nerr++; $display("FAIL timeout_idle: done %b busy %b want 0 0", bus.CMD_DONE, bus.BUSY); end
    pulse_clr();
    nvec++; if (bus.TIMEOUT_STICKY !== 1'b0) begin nerr++; $display("FAIL timeout_clear: got %b want 0", bus.TIMEOUT_STICKY); end
  endtask

  task automatic test_back_to_back();
    int n;
    send(8'h1B); send(8'h21);
    wait_start(4, n);
    nvec++; if (n !== 1 || bus.DEBUG_COMMAND !== 6'h21) begin nerr++; $display("FAIL b2b_first: lat %0d cmd %h want 1 21", n, bus.DEBUG_COMMAND); end
    send(8'h1B); send(8'h22);
    nvec++; if (bus.OVERFLOW_STICKY !== 1'b0) begin nerr++; $display("FAIL b2b_no_ovf: got %b want 0", bus.OVERFLOW_STICKY); end
    send(8'h1B); send(8'h23);
    nvec++; if (bus.OVERFLOW_STICKY !== 1'b1 || bus.BUSY !== 1'b1) begin nerr++; $display("FAIL b2b_ovf: ovf %b busy %b want 1 1", bus.OVERFLOW_STICKY, bus.BUSY); end
    finish_cmd(4, 1'b0, n);
    nvec++; if (n !== 3 || bus.DEBUG_START !== 1'b0) begin nerr++; $display("FAIL b2b_done: lat %0d start %b want 3 0", n, bus.DEBUG_START); end
    step();
    nvec++; if (bus.DEBUG_START !== 1'b1 || bus.DEBUG_COMMAND !== 6'h22) begin nerr++; $display("FAIL b2b_second: start %b cmd %h want 1 22", bus.DEBUG_START, bus.DEBUG_COMMAND); end
    finish_cmd(5, 1'b0, n);
    nvec++; if (n !== 3 || bus.CMD_PASS !== 1'b1) begin nerr++; $display("FAIL b2b_second_done: lat %0d pass %b want 3 1", n, bus.CMD_PASS); end
    step();
    nvec++; if (bus.BUSY !== 1'b0 || bus.DEBUG_START !== 1'b0) begin nerr++; $display("FAIL b2b_dropped: busy %b start %b want 0 0", bus.BUSY, bus.DEBUG_START); end
    pulse_clr();
    nvec++; if (bus.OVERFLOW_STICKY !== 1'b0) begin nerr++; $display("FAIL ovf_clear: got %b want 0", bus.OVERFLOW_STICKY); end
  endtask

  task automatic test_deferred_disable();
    int n;
    logic en_before;
    send(8'h1B); send(rand_cmd_byte());
    wait_start(4, n);
    bus.DEBUG_RUNNING = 1'b1;
    repeat (3) step();
    send(8'h1B); send(8'h12);
    nvec++; if (bus.DEBUG_TEST_EN !== 1'b1) begin nerr++; $display("FAIL defer_hold: got %b want 1", bus.DEBUG_TEST_EN); end
    step(); step();
    bus.DEBUG_RUNNING = 1'b0;
    n = -1;
    en_before = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      en_before = bus.DEBUG_TEST_EN;
      step();
      if (bus.CMD_DONE === 1'b1) begin n = i; break; end
    end
    nvec++; if (n !== 3 || en_before !== 1'b1) begin nerr++; $display("FAIL defer_pre_done: lat %0d en %b want 3 1", n, en_before); end
    nvec++; if (bus.DEBUG_TEST_EN !== 1'b0) begin nerr++; $display("FAIL defer_apply: got %b want 0", bus.DEBUG_TEST_EN); end
  endtask

  task automatic test_gating();
    logic [7:0] b;
    logic started;
    int n;
    b = rand_cmd_byte();
    send(8'h1B); send(b);
    started = 1'b0;
    repeat (5) begin step(); started |= bus.DEBUG_START; end
    nvec++; if (started !== 1'b0 || bus.BUSY !== 1'b1) begin nerr++; $display("FAIL gate_hold: start %b busy %b want 0 1", started, bus.BUSY); end
    send(8'h1B); send(8'h11);
    wait_start(3, n);
    nvec++; if (n !== 1 || bus.DEBUG_COMMAND !== b[5:0]) begin nerr++; $display("FAIL gate_release: lat %0d cmd %h want 1 %h", n, bus.DEBUG_COMMAND, b[5:0]); end
    finish_cmd(3, 1'b0, n);
    nvec++; if (n !== 3) begin nerr++; $display("FAIL gate_done: got %0d want 3", n); end
    step();
  endtask

  task automatic test_parser_edges();
    send(8'h1B); send(8'h12);
    nvec++; if (bus.DEBUG_TEST_EN !== 1'b0) begin nerr++; $display("FAIL idle_disable: got %b want 0", bus.DEBUG_TEST_EN); end
    send(8'h1B); send(8'h1B); send(8'h11);
    nvec++; if (bus.DEBUG_TEST_EN !== 1'b1) begin nerr++; $display("FAIL double_esc: got %b want 1", bus.DEBUG_TEST_EN); end
    send(8'h1B); send(8'h12);
    send(8'h11);
    nvec++; if (bus.DEBUG_TEST_EN !== 1'b0) begin nerr++; $display("FAIL bare_11: got %b want 0", bus.DEBUG_TEST_EN); end
    send(8'h1B); send(8'h40);
    nvec++; if (bus.DEBUG_TEST_EN !== 1'b0 || bus.BUSY !== 1'b0) begin nerr++; $display("FAIL esc_40: en %b busy %b want 0 0", bus.DEBUG_TEST_EN, bus.BUSY); end
    send(8'h25);
    nvec++; if (bus.BUSY !== 1'b0) begin nerr++; $display("FAIL bare_cmd: got %b want 0", bus.BUSY); end
    send(8'h1B); send(8'h11);
  endtask

  task automatic test_reset_midop();
    logic [15:0] outs;
    logic saw;
    int n;
    send(8'h1B); send(rand_cmd_byte());
    wait_start(4, n);
    step();
    send(8'h1B); send(rand_cmd_byte());
    nvec++; if (bus.BUSY !== 1'b1) begin nerr++; $display("FAIL midop_busy: got %b want 1", bus.BUSY); end
    RESET = 1'b1;
    step();
    outs = {bus.DEBUG_TEST_EN, bus.DEBUG_COMMAND, bus.DEBUG_START, bus.BUSY, bus.CMD_DONE,
            bus.CMD_PASS, bus.ERR_STICKY, bus.TIMEOUT_STICKY, bus.OVERFLOW_STICKY};
    nvec++; if (outs !== 16'h0) begin nerr++; $display("FAIL midop_reset: got %h want 0000", outs); end
    RESET = 1'b0;
    saw = 1'b0;
    repeat (24) begin step(); saw |= bus.CMD_DONE | bus.DEBUG_START | bus.BUSY; end
    nvec++; if (saw !== 1'b0) begin nerr++; $display("FAIL midop_quiet: got %b want 0", saw); end
  endtask

  // Random byte stream while disabled: reference tracks ESC state, the single slot and overflow.
  task automatic test_random_parser();
    logic [7:0] b;
    logic       m_esc, m_pend, m_ovf;
    logic [5:0] m_cmd;
    int         n;
    m_esc = 1'b0; m_pend = 1'b0; m_ovf = 1'b0; m_cmd = 6'h0;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: b = 8'h1B;
        1: b = rand_cmd_byte();
        2: b = 8'h12;
        default: b = 8'($urandom_range(0, 255));
      endcase
      if (b == 8'h11) b = 8'h10;
      send(b);
      if (b == 8'h1B) m_esc = 1'b1;
      else if (m_esc) begin
        m_esc = 1'b0;
        if (b >= 8'h20 && b <= 8'h3F) begin
          if (!m_pend) begin m_pend = 1'b1; m_cmd = b[5:0]; end
          else m_ovf = 1'b1;
        end
      end
      nvec++; if (bus.BUSY !== m_pend || bus.OVERFLOW_STICKY !== m_ovf || bus.DEBUG_TEST_EN !== 1'b0) begin
        nerr++; $display("FAIL rand_parse[%0d] byte %h: busy %b ovf %b en %b want %b %b 0", i, b, bus.BUSY, bus.OVERFLOW_STICKY, bus.DEBUG_TEST_EN, m_pend, m_ovf);
      end
    end
    send(8'h1B); send(8'h11);
    wait_start(3, n);
    if (m_pend) begin
      nvec++; if (n !== 1 || bus.DEBUG_COMMAND !== m_cmd) begin nerr++; $display("FAIL rand_issue: lat %0d cmd %h want 1 %h", n, bus.DEBUG_COMMAND, m_cmd); end
      finish_cmd(3, 1'b0, n);
    end else begin
      nvec++; if (n !== -1) begin nerr++; $display("FAIL rand_no_issue: got %0d want -1", n); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_enable_cmd();
    test_error();
    test_timeout();
    test_back_to_back();
    test_deferred_disable();
    test_gating();
    test_parser_edges();
    test_reset_midop();
    test_random_parser();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
